// File: rtl/calc_pkg.sv
// Shared key codes, FSM state encoding and default operand size for the
// calculator entry controller.
package calc_pkg;

    localparam int unsigned DIGITS_DEF = 6;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    typedef enum logic [2:0] {
        ENT_A  = 3'd0,
        OP     = 3'd1,
        ENT_B  = 3'd2,
        WAIT   = 3'd3,
        RESULT = 3'd4,
        ERR    = 3'd5
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// One BCD operand register with digit counter: shift-in append with
// leading-zero suppression and saturation, plus clear and parallel load.
module bcd_entry_reg
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF,
    parameter int unsigned DW     = 4*DIGITS,
    parameter int unsigned CW     = $clog2(DIGITS+1)
) (
    input  logic          CLK_1K,
    input  logic          RST,
    input  logic          clr,
    input  logic          load,
    input  logic          append,
    input  logic [3:0]    digit,
    input  logic [DW-1:0] load_val,
    input  logic [CW-1:0] load_cnt,
    output logic [DW-1:0] value,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

    logic do_shift;
    assign do_shift = append && (cnt < MAX_CNT) && !((digit == 4'd0) && (cnt == '0));

    always_ff @(posedge CLK_1K or posedge RST) begin
        if (RST) begin
            value <= '0;
            cnt   <= '0;
        end else if (clr) begin
            value <= '0;
            cnt   <= '0;
        end else if (load) begin
            value <= load_val;
            cnt   <= load_cnt;
        end else if (do_shift) begin
            value <= {value[DW-5:0], digit};
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/calc_entry_fsm.sv
// Calculator key-entry controller: collects two BCD operands and an operator,
// hands them to an external ALU and sequences result/chaining/error handling.
module calc_entry_fsm
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF,
    parameter int unsigned DW     = 4*DIGITS
) (
    input  logic                         CLK_1K,
    input  logic                         RST,
    input  logic                         key_valid,
    input  logic [3:0]                   key_value,
    input  logic                         alu_done,
    input  logic                         alu_err,
    input  logic [DW-1:0]                alu_result,
    output logic [DW-1:0]                num_a,
    output logic [DW-1:0]                num_b,
    output logic [3:0]                   opcode,
    output logic                         alu_start,
    output logic [DW-1:0]                disp_num,
    output logic [$clog2(DIGITS+1)-1:0]  cnt_a,
    output logic [$clog2(DIGITS+1)-1:0]  cnt_b,
    output logic [2:0]                   state,
    output logic                         err
);

    localparam int unsigned CW = $clog2(DIGITS+1);

    state_t        st;
    logic [3:0]    pend;
    logic          k_digit, k_op, k_eq, k_clr;
    logic          done_ok, done_bad;
    logic          a_load, a_append, b_clr, b_load, b_append;
    logic [DW-1:0] key_ext, a_load_val;
    logic [CW-1:0] key_cnt, a_load_cnt;

    assign k_digit = key_valid && is_digit(key_value);
    assign k_op    = key_valid && is_op(key_value);
    assign k_eq    = key_valid && (key_value == KEY_EQ);
    assign k_clr   = key_valid && (key_value == KEY_CLR);

    // alu_start doubles as the "first cycle in WAIT" flag, masking alu_done there
    assign done_ok  = (st == WAIT) && !alu_start && !k_clr && alu_done && !alu_err;
    assign done_bad = (st == WAIT) && !alu_start && !k_clr && alu_done &&  alu_err;

    assign key_ext = {{(DW-4){1'b0}}, key_value};
    assign key_cnt = {{(CW-1){1'b0}}, (key_value != 4'd0)};

    always_comb begin
        a_load     = done_ok || ((st == RESULT) && k_digit);
        a_load_val = done_ok ? alu_result : key_ext;
        a_load_cnt = done_ok ? CW'(DIGITS) : key_cnt;
        a_append   = (st == ENT_A) && k_digit;
        b_clr      = k_clr || done_ok;
        // first B digit from OP is a load so num_b starts fresh
        b_load     = (st == OP) && k_digit;
        b_append   = (st == ENT_B) && k_digit;
    end

    bcd_entry_reg #(.DIGITS(DIGITS), .DW(DW), .CW(CW)) u_reg_a (
        .CLK_1K   (CLK_1K),
        .RST      (RST),
        .clr      (k_clr),
        .load     (a_load),
        .append   (a_append),
        .digit    (key_value),
        .load_val (a_load_val),
        .load_cnt (a_load_cnt),
        .value    (num_a),
        .cnt      (cnt_a)
    );

    bcd_entry_reg #(.DIGITS(DIGITS), .DW(DW), .CW(CW)) u_reg_b (
        .CLK_1K   (CLK_1K),
        .RST      (RST),
        .clr      (b_clr),
        .load     (b_load),
        .append   (b_append),
        .digit    (key_value),
        .load_val (key_ext),
        .load_cnt (key_cnt),
        .value    (num_b),
        .cnt      (cnt_b)
    );

    always_ff @(posedge CLK_1K or posedge RST) begin
        if (RST) begin
            st        <= ENT_A;
            opcode    <= '0;
            pend      <= '0;
            alu_start <= 1'b0;
            err       <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            if (k_clr) begin
                st     <= ENT_A;
                opcode <= '0;
                pend   <= '0;
                err    <= 1'b0;
            end else begin
                case (st)
                    ENT_A: begin
                        if (k_op) begin
                            opcode <= key_value;
                            st     <= OP;
                        end
                    end
                    OP: begin
                        if (k_op) begin
                            opcode <= key_value;
                        end else if (k_digit) begin
                            st <= ENT_B;
                        end
                    end
                    ENT_B: begin
                        if (k_eq || k_op) begin
                            pend      <= k_op ? key_value : 4'd0;
                            st        <= WAIT;
                            alu_start <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (done_bad) begin
                            st  <= ERR;
                            err <= 1'b1;
                        end else if (done_ok) begin
                            opcode <= pend;
                            st     <= (pend != 4'd0) ? OP : RESULT;
                        end
                    end
                    RESULT: begin
                        if (k_digit) begin
                            st <= ENT_A;
                        end else if (k_op) begin
                            opcode <= key_value;
                            st     <= OP;
                        end
                    end
                    ERR:     ;
                    default: st <= ENT_A;
                endcase
            end
        end
    end

    assign state    = st;
    assign disp_num = (st == ENT_B) ? num_b : num_a;

endmodule
